// File: rtl/sap_control_sequencer_if.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer_if
//   Bundles the sequencer's decode inputs and the control word it drives into
//   the SAP datapath (PC, MAR, RAM, IR, A, B, ALU, OUT).
//   master : the control sequencer (consumes opcode/flags, drives controls)
//   slave  : the datapath (drives opcode/flags, consumes controls)
// Signals
//   opcode[OPC_W-1:0]  IR upper nibble, valid from T2
//   cf, zf             registered ALU carry / zero flags
//   t_state[2:0]       current T-step
//   pc_out .. out_load_n  control word (*_n active low)
//   halted             sticky halt indicator
// -----------------------------------------------------------------------------
interface sap_control_sequencer_if #(
   parameter int OPC_W = 4
);
   logic [OPC_W-1:0] opcode;
   logic             cf;
   logic             zf;
   logic [2:0]       t_state;
   logic             pc_out;
   logic             pc_inc;
   logic             pc_load;
   logic             mar_load_n;
   logic             ram_out;
   logic             ir_load_n;
   logic             ir_out;
   logic             a_load_n;
   logic             a_out;
   logic             b_load_n;
   logic             alu_out;
   logic             alu_sub;
   logic             out_load_n;
   logic             halted;

   modport master (
      input  opcode, cf, zf,
      output t_state, pc_out, pc_inc, pc_load, mar_load_n, ram_out, ir_load_n,
             ir_out, a_load_n, a_out, b_load_n, alu_out, alu_sub, out_load_n,
             halted
   );

   modport slave (
      output opcode, cf, zf,
      input  t_state, pc_out, pc_inc, pc_load, mar_load_n, ram_out, ir_load_n,
             ir_out, a_load_n, a_out, b_load_n, alu_out, alu_sub, out_load_n,
             halted
   );
endinterface

// File: rtl/sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer
//   Microcoded control FSM for the 8-bit SAP bus CPU. Each instruction is a
//   fetch (T0-T1) followed by a variable-length execute (T2-T4). The control
//   word is a pure combinational decode of {halted, t_state, opcode, cf, zf}.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; all controls inactive while low
//   bus    sap_control_sequencer_if.master (opcode/flags in, controls out)
// Parameters
//   OPC_W   opcode width; undefined opcodes execute as NOP
//   LAST_T  index of the final T-state; t_state wraps LAST_T -> 0
// -----------------------------------------------------------------------------
module sap_control_sequencer #(
   parameter int OPC_W  = 4,
   parameter int LAST_T = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sap_control_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } t_e;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } op_e;

   t_e   t_q, t_d;
   logic halted_q, halted_d;
   logic end_instr;
   logic [3:0] op;

   assign op          = 4'(bus.opcode);
   assign bus.t_state = t_q;
   assign bus.halted  = halted_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_q      <= T0;
         halted_q <= 1'b0;
      end else begin
         t_q      <= t_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      end_instr      = 1'b0;
      halted_d       = halted_q;
      t_d            = (t_q == 3'(LAST_T)) ? T0 : t_e'(t_q + 3'd1);
      bus.pc_out     = 1'b0;
      bus.pc_inc     = 1'b0;
      bus.pc_load    = 1'b0;
      bus.mar_load_n = 1'b1;
      bus.ram_out    = 1'b0;
      bus.ir_load_n  = 1'b1;
      bus.ir_out     = 1'b0;
      bus.a_load_n   = 1'b1;
      bus.a_out      = 1'b0;
      bus.b_load_n   = 1'b1;
      bus.alu_out    = 1'b0;
      bus.alu_sub    = 1'b0;
      bus.out_load_n = 1'b1;

      // rst_n gates the decode so no control can pulse while reset is held,
      // including the cycle in which an async reset lands mid-instruction.
      if (halted_q) begin
         t_d = T0;
      end else if (rst_n) begin
         case (t_q)
            T0: begin
               bus.pc_out     = 1'b1;
               bus.mar_load_n = 1'b0;
            end
            T1: begin
               bus.ram_out   = 1'b1;
               bus.ir_load_n = 1'b0;
               bus.pc_inc    = 1'b1;
            end
            T2: begin
               case (op)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     bus.ir_out     = 1'b1;
                     bus.mar_load_n = 1'b0;
                  end
                  OP_LDI: begin
                     bus.ir_out   = 1'b1;
                     bus.a_load_n = 1'b0;
                     end_instr    = 1'b1;
                  end
                  OP_JMP: begin
                     bus.ir_out  = 1'b1;
                     bus.pc_load = 1'b1;
                     end_instr   = 1'b1;
                  end
                  OP_JC: begin
                     bus.ir_out  = bus.cf;
                     bus.pc_load = bus.cf;
                     end_instr   = 1'b1;
                  end
                  OP_JZ: begin
                     bus.ir_out  = bus.zf;
                     bus.pc_load = bus.zf;
                     end_instr   = 1'b1;
                  end
                  OP_OUT: begin
                     bus.a_out      = 1'b1;
                     bus.out_load_n = 1'b0;
                     end_instr      = 1'b1;
                  end
                  OP_HLT: begin
                     halted_d  = 1'b1;
                     end_instr = 1'b1;
                  end
                  default: end_instr = 1'b1;  // NOP and undefined opcodes
               endcase
            end
            T3: begin
               case (op)
                  OP_LDA: begin
                     bus.ram_out  = 1'b1;
                     bus.a_load_n = 1'b0;
                     end_instr    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     bus.ram_out  = 1'b1;
                     bus.b_load_n = 1'b0;
                     bus.alu_sub  = (op == OP_SUB);
                  end
                  default: end_instr = 1'b1;
               endcase
            end
            T4: begin
               if (op == OP_ADD || op == OP_SUB) begin
                  bus.alu_out  = 1'b1;
                  bus.a_load_n = 1'b0;
                  bus.alu_sub  = (op == OP_SUB);
               end
               end_instr = 1'b1;
            end
            default: end_instr = 1'b1;
         endcase
         if (end_instr) t_d = T0;
      end
   end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_control_sequencer
//   Self-checking bench for sap_control_sequencer: a table of per-cycle
//   {opcode, flags, expected t_state, expected asserted controls} records,
//   followed by hand-written halt / async-reset sequences and a random-opcode
//   run that checks the bus-driver one-hot-or-zero rule every cycle.
//   Expected controls are expressed as a mask of *asserted* signals, so
//   active-low outputs appear as 1 when they are driven low.
// -----------------------------------------------------------------------------
module tb_sap_control_sequencer;

   localparam logic [12:0] PC_OUT  = 13'h1000;
   localparam logic [12:0] PC_INC  = 13'h0800;
   localparam logic [12:0] PC_LD   = 13'h0400;
   localparam logic [12:0] MAR_LD  = 13'h0200;
   localparam logic [12:0] RAM_OUT = 13'h0100;
   localparam logic [12:0] IR_LD   = 13'h0080;
   localparam logic [12:0] IR_OUT  = 13'h0040;
   localparam logic [12:0] A_LD    = 13'h0020;
   localparam logic [12:0] A_OUT   = 13'h0010;
   localparam logic [12:0] B_LD    = 13'h0008;
   localparam logic [12:0] ALU_OUT = 13'h0004;
   localparam logic [12:0] ALU_SUB = 13'h0002;
   localparam logic [12:0] OUT_LD  = 13'h0001;
   localparam logic [12:0] NONE    = 13'h0000;
   localparam logic [12:0] FETCH0  = PC_OUT | MAR_LD;
   localparam logic [12:0] FETCH1  = RAM_OUT | IR_LD | PC_INC;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic        cf;
      logic        zf;
      logic [2:0]  t;
      logic [12:0] ctl;
   } vec_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   vec_t vecs[$];

   sap_control_sequencer_if #(.OPC_W(4)) bus_if ();

   sap_control_sequencer #(.OPC_W(4), .LAST_T(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] asserted();
      return {bus_if.pc_out, bus_if.pc_inc, bus_if.pc_load, ~bus_if.mar_load_n,
              bus_if.ram_out, ~bus_if.ir_load_n, bus_if.ir_out, ~bus_if.a_load_n,
              bus_if.a_out, ~bus_if.b_load_n, bus_if.alu_out, bus_if.alu_sub,
              ~bus_if.out_load_n};
   endfunction

   task automatic check(input string name, input logic [2:0] et,
                        input logic [12:0] ec, input logic eh);
      logic [12:0] act;
      act = asserted();
      vectors++;
      if (bus_if.t_state !== et || act !== ec || bus_if.halted !== eh) begin
         miscompares++;
         $display("FAIL %s: got t_state=%0d ctl=%h halted=%b, want t_state=%0d ctl=%h halted=%b",
                  name, bus_if.t_state, act, bus_if.halted, et, ec, eh);
      end
   endtask

   task automatic add(input string nm, input logic [3:0] op, input logic cf,
                      input logic zf, input logic [2:0] t, input logic [12:0] ctl);
      vec_t v;
      v.name = nm; v.op = op; v.cf = cf; v.zf = zf; v.t = t; v.ctl = ctl;
      vecs.push_back(v);
   endtask

   // One whole instruction: fetch plus execute steps T2..last.
   task automatic add_instr(input string nm, input logic [3:0] op, input logic cf,
                            input logic zf, input logic [12:0] c2,
                            input logic [12:0] c3, input logic [12:0] c4,
                            input int unsigned last);
      add({nm, "_t0"}, op, cf, zf, 3'd0, FETCH0);
      add({nm, "_t1"}, op, cf, zf, 3'd1, FETCH1);
      add({nm, "_t2"}, op, cf, zf, 3'd2, c2);
      if (last >= 3) add({nm, "_t3"}, op, cf, zf, 3'd3, c3);
      if (last >= 4) add({nm, "_t4"}, op, cf, zf, 3'd4, c4);
   endtask

   task automatic step_check(input string name, input logic [2:0] et,
                             input logic [12:0] ec, input logic eh);
      @(negedge clk);
      check(name, et, ec, eh);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned instrs;
      int unsigned cycles;
      int          drivers;

      vectors     = 0;
      miscompares = 0;
      rst_n          = 1'b0;
      bus_if.opcode  = 4'h0;
      bus_if.cf      = 1'b0;
      bus_if.zf      = 1'b0;

      add_instr("nop",   4'h0, 1'b0, 1'b0, NONE, NONE, NONE, 2);
      add_instr("lda",   4'h1, 1'b0, 1'b0, IR_OUT | MAR_LD, RAM_OUT | A_LD, NONE, 3);
      add_instr("add",   4'h2, 1'b0, 1'b0, IR_OUT | MAR_LD, RAM_OUT | B_LD,
                ALU_OUT | A_LD, 4);
      add_instr("sub",   4'h3, 1'b0, 1'b0, IR_OUT | MAR_LD, RAM_OUT | B_LD | ALU_SUB,
                ALU_OUT | A_LD | ALU_SUB, 4);
      add_instr("ldi",   4'h5, 1'b0, 1'b0, IR_OUT | A_LD, NONE, NONE, 2);
      add_instr("jmp",   4'h6, 1'b0, 1'b0, IR_OUT | PC_LD, NONE, NONE, 2);
      add_instr("jc0",   4'h7, 1'b0, 1'b1, NONE, NONE, NONE, 2);
      add_instr("jc1",   4'h7, 1'b1, 1'b0, IR_OUT | PC_LD, NONE, NONE, 2);
      add_instr("jz0",   4'h8, 1'b1, 1'b0, NONE, NONE, NONE, 2);
      add_instr("jz1",   4'h8, 1'b0, 1'b1, IR_OUT | PC_LD, NONE, NONE, 2);
      add_instr("out",   4'hE, 1'b0, 1'b0, A_OUT | OUT_LD, NONE, NONE, 2);
      add_instr("und4",  4'h4, 1'b1, 1'b1, NONE, NONE, NONE, 2);
      add_instr("und9",  4'h9, 1'b1, 1'b1, NONE, NONE, NONE, 2);
      add_instr("undd",  4'hD, 1'b0, 1'b0, NONE, NONE, NONE, 2);
      add_instr("nop2",  4'h0, 1'b0, 1'b0, NONE, NONE, NONE, 2);

      // Reset held: controls inactive, no stepping.
      #2;
      check("reset", 3'd0, NONE, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", 3'd0, NONE, 1'b0);
      rst_n = 1'b1;

      // Table: one record per clock cycle, released straight into T0.
      foreach (vecs[i]) begin
         bus_if.opcode = vecs[i].op;
         bus_if.cf     = vecs[i].cf;
         bus_if.zf     = vecs[i].zf;
         step_check(vecs[i].name, vecs[i].t, vecs[i].ctl, 1'b0);
      end

      // HLT: halted rises at the T2 edge, then everything stays frozen.
      bus_if.opcode = 4'hF;
      step_check("hlt_t0", 3'd0, FETCH0, 1'b0);
      step_check("hlt_t1", 3'd1, FETCH1, 1'b0);
      step_check("hlt_t2", 3'd2, NONE, 1'b0);
      for (int unsigned k = 0; k < 20; k++) begin
         bus_if.opcode = 4'($urandom_range(0, 15));
         bus_if.cf     = 1'($urandom_range(0, 1));
         bus_if.zf     = 1'($urandom_range(0, 1));
         step_check("halted", 3'd0, NONE, 1'b1);
      end

      // Async reset while halted clears the halt.
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_clears_halt", 3'd0, NONE, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Async reset in the middle of LDA T3.
      bus_if.opcode = 4'h1;
      bus_if.cf     = 1'b0;
      bus_if.zf     = 1'b0;
      step_check("lda2_t0", 3'd0, FETCH0, 1'b0);
      step_check("lda2_t1", 3'd1, FETCH1, 1'b0);
      step_check("lda2_t2", 3'd2, IR_OUT | MAR_LD, 1'b0);
      @(negedge clk);
      check("lda2_t3", 3'd3, RAM_OUT | A_LD, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_t3", 3'd0, NONE, 1'b0);
      @(posedge clk);
      #1;
      check("rst_mid_hold", 3'd0, NONE, 1'b0);
      rst_n = 1'b1;
      step_check("post_rst_t0", 3'd0, FETCH0, 1'b0);
      step_check("post_rst_t1", 3'd1, FETCH1, 1'b0);

      // Random opcodes (no HLT): at most one bus driver per cycle.
      instrs = 0;
      cycles = 0;
      while (instrs <= 500 && cycles < 4000) begin
         if (bus_if.t_state == 3'd0) begin
            instrs++;
            bus_if.opcode = 4'($urandom_range(0, 14));
         end
         bus_if.cf = 1'($urandom_range(0, 1));
         bus_if.zf = 1'($urandom_range(0, 1));
         @(negedge clk);
         drivers = int'(bus_if.pc_out) + int'(bus_if.ram_out) + int'(bus_if.ir_out) +
                   int'(bus_if.a_out) + int'(bus_if.alu_out);
         vectors++;
         if (drivers > 1 || bus_if.t_state > 3'd4 || bus_if.halted !== 1'b0) begin
            miscompares++;
            $display("FAIL bus_onehot: got drivers=%0d t_state=%0d halted=%b, want drivers<=1 t_state<=4 halted=0",
                     drivers, bus_if.t_state, bus_if.halted);
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      vectors++;
      if (cycles >= 4000) begin
         miscompares++;
         $display("FAIL random_budget: got %0d instructions in %0d cycles, want 501", instrs, cycles);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
